// File: rtl/vga_sync_receiver.sv
// Receive-side VGA timing recovery: locks a local x/y counter pair to incoming
// active-low h_sync/v_sync, regenerates pixel coordinates/index and flags timing violations.
module vga_sync_receiver #(
   parameter  int H_VISIBLE_AREA = 640,
   parameter  int H_FRONT_PORCH  = 16,
   parameter  int H_SYNC_PULSE   = 96,
   parameter  int H_BACK_PORCH   = 48,
   parameter  int V_VISIBLE_AREA = 480,
   parameter  int V_FRONT_PORCH  = 10,
   parameter  int V_SYNC_PULSE   = 2,
   parameter  int V_BACK_PORCH   = 33,
   localparam int H_LINE = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
   localparam int V_LINE = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
   localparam int HW     = $clog2(H_LINE),
   localparam int VW     = $clog2(V_LINE),
   localparam int IW     = $clog2(H_VISIBLE_AREA * V_VISIBLE_AREA)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          h_sync,
   input  logic          v_sync,
   output logic [HW-1:0] horizontal_coord,
   output logic [VW-1:0] vertical_coord,
   output logic [IW-1:0] idx,
   output logic          valid,
   output logic          locked,
   output logic          frame_start,
   output logic          lock_error,
   output logic [7:0]    error_count
);

   localparam int H_SYNC_START = H_VISIBLE_AREA + H_FRONT_PORCH;
   localparam int V_SYNC_START = V_VISIBLE_AREA + V_FRONT_PORCH;

   localparam logic [HW-1:0] H_LAST = HW'(H_LINE - 1);
   localparam logic [HW-1:0] H_SS   = HW'(H_SYNC_START);
   localparam logic [HW-1:0] H_SE   = HW'((H_SYNC_START + H_SYNC_PULSE) % H_LINE);
   localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE_AREA);
   localparam logic [VW-1:0] V_LAST = VW'(V_LINE - 1);
   localparam logic [VW-1:0] V_SS   = VW'(V_SYNC_START);
   localparam logic [VW-1:0] V_SE   = VW'((V_SYNC_START + V_SYNC_PULSE) % V_LINE);
   localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE_AREA);

   typedef enum logic [1:0] {SEARCH_H, SEARCH_V, LOCKED} state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] h_q, h_d, x_eff;
   logic [VW-1:0] v_q, v_d, y_base;
   logic [IW-1:0] idx_q, idx_d;
   logic          h_prev_q, v_prev_q;
   logic          v_seen_q, v_seen_d;
   logic          lock_error_q, lock_error_d;
   logic [7:0]    error_count_q, error_count_d;
   logic          h_fall, h_rise, v_fall, v_rise;
   logic          realign, vload, err, wrap, h_at_last, valid_d;

   assign h_fall    = ~h_sync & h_prev_q;
   assign h_rise    = h_sync & ~h_prev_q;
   assign v_fall    = ~v_sync & v_prev_q;
   assign v_rise    = v_sync & ~v_prev_q;
   assign h_at_last = (h_q == H_LAST);

   always_comb begin
      state_d = state_q;
      realign = 1'b0;
      vload   = 1'b0;
      err     = 1'b0;
      unique case (state_q)
         SEARCH_H: begin
            if (h_fall) begin
               realign = 1'b1;
               state_d = SEARCH_V;
            end
         end
         SEARCH_V: begin
            realign = h_fall;
            if (v_fall) begin
               vload   = 1'b1;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (h_fall && (h_q != H_SS)) begin
               realign = 1'b1;
               err     = 1'b1;
               state_d = SEARCH_V;
            end
            // Any of these loses lock entirely; they override a pending realign-only drop.
            if ((h_q == H_SS && !h_fall) ||
                (h_q == H_SE && !h_rise) ||
                (h_rise && h_q != H_SE) ||
                (v_fall && v_q != V_SS) ||
                (h_at_last && v_q == V_SS && !(v_seen_q || v_fall)) ||
                (v_rise && v_q != V_SE)) begin
               err     = 1'b1;
               state_d = SEARCH_H;
            end
         end
         default: state_d = SEARCH_H;
      endcase
   end

   // A realign redefines the current cycle as x = H_SYNC_START, so the wrap decision
   // for both counters is taken from that effective position.
   always_comb begin
      x_eff  = realign ? H_SS : h_q;
      wrap   = (x_eff == H_LAST);
      h_d    = wrap ? '0 : x_eff + 1'b1;
      y_base = vload ? V_SS : v_q;
      v_d    = wrap ? ((y_base == V_LAST) ? '0 : y_base + 1'b1) : y_base;
      v_seen_d = wrap ? 1'b0 : (v_seen_q | v_fall);
   end

   // Visible pixels are always entered at (0,0) after lock, so a running +1 tracks the index.
   always_comb begin
      valid_d = (state_d == LOCKED) && (h_d < H_VIS) && (v_d < V_VIS);
      idx_d   = idx_q;
      if (valid_d) begin
         idx_d = (h_d == '0 && v_d == '0) ? '0 : idx_q + 1'b1;
      end
      lock_error_d  = err;
      error_count_d = (err && error_count_q != 8'hFF) ? error_count_q + 8'd1 : error_count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= SEARCH_H;
         h_q           <= '0;
         v_q           <= '0;
         idx_q         <= '0;
         h_prev_q      <= 1'b0;
         v_prev_q      <= 1'b0;
         v_seen_q      <= 1'b0;
         lock_error_q  <= 1'b0;
         error_count_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         h_q           <= h_d;
         v_q           <= v_d;
         idx_q         <= idx_d;
         h_prev_q      <= h_sync;
         v_prev_q      <= v_sync;
         v_seen_q      <= v_seen_d;
         lock_error_q  <= lock_error_d;
         error_count_q <= error_count_d;
      end
   end

   assign horizontal_coord = h_q;
   assign vertical_coord   = v_q;
   assign idx              = idx_q;
   assign locked           = (state_q == LOCKED);
   assign valid            = locked && (h_q < H_VIS) && (v_q < V_VIS);
   assign frame_start      = locked && (h_q == '0) && (v_q == '0);
   assign lock_error       = lock_error_q;
   assign error_count      = error_count_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced video mode (15x9 total, 8x4 visible)
// driven by an ideal sync generator with per-line fault knobs.
module tb_vga_sync_receiver;

   localparam int HV = 8, HF = 2, HP = 3, HB = 2;
   localparam int VV = 4, VF = 1, VP = 2, VB = 2;
   localparam int HL  = HV + HF + HP + HB;   // 15
   localparam int VL  = VV + VF + VP + VB;   // 9
   localparam int HSS = HV + HF;             // 10
   localparam int VSS = VV + VF;             // 5
   localparam int HW  = $clog2(HL);
   localparam int VW  = $clog2(VL);
   localparam int IW  = $clog2(HV * VV);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          h_sync = 1'b1;
   logic          v_sync = 1'b1;
   logic [HW-1:0] horizontal_coord;
   logic [VW-1:0] vertical_coord;
   logic [IW-1:0] idx;
   logic          valid, locked, frame_start, lock_error;
   logic [7:0]    error_count;

   vga_sync_receiver #(
      .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HP), .H_BACK_PORCH(HB),
      .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VP), .V_BACK_PORCH(VB)
   ) dut (
      .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
      .horizontal_coord(horizontal_coord), .vertical_coord(vertical_coord), .idx(idx),
      .valid(valid), .locked(locked), .frame_start(frame_start),
      .lock_error(lock_error), .error_count(error_count)
   );

   always #5 clk = ~clk;

   int err_cnt = 0;
   int chk_cnt = 0;
   int gx = 0, gy = 0;
   int shift_line = -1, omit_line = -1, short_line = -1;
   bit v_late = 1'b0, hold_low = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic h, input logic v);
      h_sync = h;
      v_sync = v;
      @(posedge clk);
      #1;
   endtask

   // Presents position (gx,gy), then advances; afterwards the DUT should show the new (gx,gy).
   task automatic step();
      int   s, w;
      logic h, v;
      s = HSS + ((gy == shift_line) ? 3 : 0);
      w = HP - ((gy == short_line) ? 1 : 0);
      h = !((gx >= s) && (gx < s + w) && (gy != omit_line));
      if (hold_low) h = 1'b0;
      if (v_late) v = !((gy >= VSS + 1) && (gy < VSS + 1 + VP));
      else        v = !((gy >= VSS) && (gy < VSS + VP));
      if (gx == HL - 1) begin
         gx = 0;
         gy = (gy == VL - 1) ? 0 : gy + 1;
      end else begin
         gx++;
      end
      drive(h, v);
   endtask

   task automatic run_to(input int tx, input int ty);
      int n = 0;
      while (!(gx == tx && gy == ty) && n < HL * VL + 1) begin
         step();
         n++;
      end
      check("run_to_reached", int'(gx == tx && gy == ty), 1);
   endtask

   task automatic wait_lock(input string tag);
      int n = 0;
      while (!locked && n < HL * VL + HL + 2) begin
         step();
         n++;
      end
      check(tag, int'(locked), 1);
      check({tag, "_x"}, int'(horizontal_coord), gx);
      check({tag, "_y"}, int'(vertical_coord), gy);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_x"}, int'(horizontal_coord), 0);
      check({tag, "_y"}, int'(vertical_coord), 0);
      check({tag, "_idx"}, int'(idx), 0);
      check({tag, "_valid"}, int'(valid), 0);
      check({tag, "_locked"}, int'(locked), 0);
      check({tag, "_fs"}, int'(frame_start), 0);
      check({tag, "_lerr"}, int'(lock_error), 0);
      check({tag, "_ecnt"}, int'(error_count), 0);
   endtask

   task automatic clean_frames(input int nfr);
      int nv = 0, nfs = 0, last_idx = 0, ev;
      run_to(0, 0);
      for (int i = 0; i < nfr * HL * VL; i++) begin
         ev = int'(gx < HV && gy < VV);
         check("clean_x", int'(horizontal_coord), gx);
         check("clean_y", int'(vertical_coord), gy);
         check("clean_valid", int'(valid), ev);
         check("clean_fs", int'(frame_start), int'(gx == 0 && gy == 0));
         check("clean_lerr", int'(lock_error), 0);
         if (ev != 0) last_idx = gy * HV + gx;
         check("clean_idx", int'(idx), last_idx);
         nv  += ev;
         nfs += int'(gx == 0 && gy == 0);
         step();
      end
      check("clean_valid_count", nv, nfr * HV * VV);
      check("clean_frame_starts", nfs, nfr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with the stream running from an arbitrary phase.
      gx = 3; gy = 2;
      reset = 1'b1;
      repeat (2) step();
      check_reset_values("reset");
      reset = 1'b0;
      wait_lock("lock_acquire");
      clean_frames(2);
      $display("phase clean stream: checks=%0d errors=%0d", chk_cnt, err_cnt);

      // One h_sync pulse delayed by 3 cycles on line 1.
      shift_line = 1;
      run_to(HSS, 1);
      step();
      check("shift_lerr", int'(lock_error), 1);
      check("shift_locked", int'(locked), 0);
      step();
      check("shift_single_pulse", int'(lock_error), 0);
      check("shift_ecnt", int'(error_count), 1);
      run_to(HSS + 3, 1);
      step();
      check("shift_realign_x", int'(horizontal_coord), HSS + 1);
      check("shift_realign_y", int'(vertical_coord), 1);
      run_to(0, 2);
      shift_line = -1;
      wait_lock("shift_relock");
      check("shift_ecnt_after", int'(error_count), 1);
      $display("phase shifted h edge: checks=%0d errors=%0d", chk_cnt, err_cnt);

      // Missing h_sync pulse on line 2.
      omit_line = 2;
      run_to(HSS, 2);
      step();
      check("miss_lerr", int'(lock_error), 1);
      check("miss_locked", int'(locked), 0);
      run_to(0, 3);
      omit_line = -1;
      wait_lock("miss_relock");
      check("miss_ecnt", int'(error_count), 2);
      $display("phase missing h pulse: checks=%0d errors=%0d", chk_cnt, err_cnt);

      // Short h_sync pulse on line 2: rise arrives one cycle early.
      short_line = 2;
      run_to(HSS + HP - 1, 2);
      step();
      check("short_lerr", int'(lock_error), 1);
      check("short_locked", int'(locked), 0);
      step();
      check("short_single_pulse", int'(lock_error), 0);
      run_to(0, 3);
      short_line = -1;
      wait_lock("short_relock");
      check("short_ecnt", int'(error_count), 3);
      $display("phase short h pulse: checks=%0d errors=%0d", chk_cnt, err_cnt);

      // v_sync falls one line late: the wrap out of line VSS catches it first.
      run_to(0, 0);
      v_late = 1'b1;
      run_to(HL - 1, VSS);
      check("late_locked_before", int'(locked), 1);
      step();
      check("late_lerr", int'(lock_error), 1);
      check("late_locked", int'(locked), 0);
      step();
      check("late_single_pulse", int'(lock_error), 0);
      run_to(0, 0);
      v_late = 1'b0;
      wait_lock("late_relock");
      check("late_ecnt", int'(error_count), 4);
      $display("phase late v edge: checks=%0d errors=%0d", chk_cnt, err_cnt);

      // Reset mid-frame with h_sync held low through release.
      run_to(HSS + 1, 1);
      reset = 1'b1;
      hold_low = 1'b1;
      step();
      check_reset_values("midreset");
      step();
      reset = 1'b0;
      repeat (3) step();
      check("midreset_no_realign_x", int'(horizontal_coord), 3);
      check("midreset_locked", int'(locked), 0);
      hold_low = 1'b0;
      run_to(HSS, gy);
      step();
      check("midreset_realign_x", int'(horizontal_coord), HSS + 1);
      check("midreset_lerr", int'(lock_error), 0);
      $display("phase mid-frame reset: checks=%0d errors=%0d", chk_cnt, err_cnt);

      // 300 violations: lock via simultaneous h/v fall, then an early h rise.
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'b1);
         drive(1'b0, 1'b1);
         drive(1'b1, 1'b1);
         drive(1'b0, 1'b0);
         check("sat_locked", int'(locked), 1);
         drive(1'b1, 1'b0);
         check("sat_lerr", int'(lock_error), 1);
         drive(1'b1, 1'b1);
         if (i == 9) check("sat_ecnt_10", int'(error_count), 10);
      end
      check("sat_ecnt_final", int'(error_count), 255);
      check("sat_locked_final", int'(locked), 0);
      $display("phase error saturation: checks=%0d errors=%0d", chk_cnt, err_cnt);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
